// File: rtl/sysread.sv
// Console read syscall unit: stalls the processor while it reads one char
// or one signed decimal integer from the console byte stream.
module sysread (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sys,
    input  logic [31:0] i_num,
    input  logic        i_run,
    output logic        o_run,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [31:0] o_res,
    output logic        o_res_we
);

    typedef enum logic [2:0] {
        StIdle,
        StRchar,
        StRintSkip,
        StRintDig,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [31:0] res_q, res_d;
    logic        run_q, run_d;

    logic        accept;
    logic        is_digit;
    logic [31:0] digit;

    assign o_rx_ready = (state_q == StRchar) || (state_q == StRintSkip) ||
                        (state_q == StRintDig);
    assign o_res_we   = (state_q == StDone);
    assign o_run      = run_q;
    assign o_res      = res_q;

    assign accept   = i_rx_valid && o_rx_ready;
    assign is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    // Low nibble of an ASCII digit is its value.
    assign digit    = {28'b0, i_rx_data[3:0]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        res_d   = res_q;
        run_d   = 1'b0;
        case (state_q)
            StIdle: begin
                run_d = i_run;
                if (i_sys && (i_num == 32'd5)) begin
                    state_d = StRchar;
                    run_d   = 1'b0;
                end else if (i_sys && (i_num == 32'd4)) begin
                    state_d = StRintSkip;
                    run_d   = 1'b0;
                    acc_d   = 32'd0;
                    neg_d   = 1'b0;
                end
            end
            StRchar: begin
                if (accept) begin
                    res_d   = {24'b0, i_rx_data};
                    state_d = StDone;
                end
            end
            StRintSkip: begin
                if (accept) begin
                    case (i_rx_data)
                        8'h20, 8'h09, 8'h0A, 8'h0D: ;
                        8'h2D: begin
                            neg_d   = 1'b1;
                            state_d = StRintDig;
                        end
                        default: begin
                            if (is_digit) begin
                                acc_d   = digit;
                                state_d = StRintDig;
                            end else begin
                                res_d   = 32'd0;
                                state_d = StDone;
                            end
                        end
                    endcase
                end
            end
            StRintDig: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d = acc_q * 32'd10 + digit;
                    end else begin
                        res_d   = neg_q ? (32'd0 - acc_q) : acc_q;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                run_d   = i_run;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            acc_q   <= 32'd0;
            neg_q   <= 1'b0;
            res_q   <= 32'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_sysread.sv
// Directed and randomized bench for sysread, checked against a string-level
// parser model of the read char / read int syscalls.
module tb_sysread;

    typedef logic [7:0] u8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_sys = 1'b0;
    logic [31:0] i_num = 32'd0;
    logic        i_run = 1'b1;
    logic        o_run;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [31:0] o_res;
    logic        o_res_we;

    int tests = 0;
    int fails = 0;
    u8  stim[$];
    logic [31:0] last_res = 32'd0;

    sysread dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sys      (i_sys),
        .i_num      (i_num),
        .i_run      (i_run),
        .o_run      (o_run),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_res      (o_res),
        .o_res_we   (o_res_we)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_str(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(u8'(s[i]));
    endtask

    // Reference: parse the byte string as the syscall would, returning the
    // result and how many bytes the read consumes.
    function automatic void model(input bit is_char, output logic [31:0] res, output int n);
        longint v = 0;
        bit neg = 0;
        bit any = 0;
        int i = 0;
        if (is_char) begin
            res = {24'b0, stim[0]};
            n = 1;
            return;
        end
        while (stim[i] == 8'h20 || stim[i] == 8'h09 || stim[i] == 8'h0A || stim[i] == 8'h0D)
            i++;
        if (stim[i] == 8'h2D) begin
            neg = 1;
            any = 1;
            i++;
        end
        while (stim[i] >= 8'h30 && stim[i] <= 8'h39) begin
            v = (v * 10 + longint'(stim[i] - 8'h30)) % 64'h1_0000_0000;
            any = 1;
            i++;
        end
        n = i + 1;
        if (!any) res = 32'd0;
        else if (neg) res = 32'((64'h1_0000_0000 - v) % 64'h1_0000_0000);
        else res = 32'(v);
    endfunction

    // Issue a syscall and feed the consumed bytes with random gaps and
    // random stray i_sys strobes, checking the handshake and stall throughout.
    task automatic do_read(input bit is_char, input int max_gap, input string tag);
        logic [31:0] exp;
        int n;
        model(is_char, exp, n);
        i_sys = 1'b1;
        i_num = is_char ? 32'd5 : 32'd4;
        i_rx_valid = 1'b0;
        @(negedge i_clk);
        i_sys = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < $urandom_range(max_gap, 0); g++) begin
                i_rx_valid = 1'b0;
                i_sys = 1'($urandom);
                i_num = is_char ? 32'd4 : 32'd5;
                @(negedge i_clk);
            end
            chk({tag, " ready"}, 32'(o_rx_ready), 32'd1);
            chk({tag, " no_we"}, 32'(o_res_we), 32'd0);
            chk({tag, " stall"}, 32'(o_run), 32'd0);
            i_rx_valid = 1'b1;
            i_rx_data = stim[k];
            i_sys = 1'($urandom);
            @(negedge i_clk);
        end
        i_rx_valid = 1'b0;
        i_sys = 1'b0;
        chk({tag, " we"}, 32'(o_res_we), 32'd1);
        chk({tag, " res"}, o_res, exp);
        chk({tag, " done_stall"}, 32'(o_run), 32'd0);
        @(negedge i_clk);
        chk({tag, " we_low"}, 32'(o_res_we), 32'd0);
        chk({tag, " run_back"}, 32'(o_run), 32'(i_run));
        chk({tag, " res_hold"}, o_res, exp);
        chk({tag, " idle_ready"}, 32'(o_rx_ready), 32'd0);
        last_res = exp;
    endtask

    initial begin
        int nws;
        int nd;
        bit minus;
        logic [31:0] num;

        @(negedge i_clk);
        chk("rst run", 32'(o_run), 32'd0);
        chk("rst res", o_res, 32'd0);
        chk("rst we", 32'(o_res_we), 32'd0);
        chk("rst ready", 32'(o_rx_ready), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("idle run", 32'(o_run), 32'd1);

        set_str("A");
        do_read(1'b1, 0, "char_A");
        set_str("  -123\n");
        do_read(1'b0, 0, "int_neg123");
        set_str("4294967297 ");
        do_read(1'b0, 1, "int_wrap");
        set_str("-2147483648\n");
        do_read(1'b0, 0, "int_min");
        set_str("-x");
        do_read(1'b0, 0, "int_minus_only");
        set_str(" q");
        do_read(1'b0, 0, "int_bad_first");

        // Long wait with no valid byte.
        i_sys = 1'b1;
        i_num = 32'd4;
        @(negedge i_clk);
        i_sys = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("wait ready", 32'(o_rx_ready), 32'd1);
            chk("wait stall", 32'(o_run), 32'd0);
            chk("wait no_we", 32'(o_res_we), 32'd0);
            @(negedge i_clk);
        end
        i_rx_valid = 1'b1;
        i_rx_data = 8'h39;
        @(negedge i_clk);
        i_rx_data = 8'h0A;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        chk("wait we", 32'(o_res_we), 32'd1);
        chk("wait res", o_res, 32'd9);
        @(negedge i_clk);

        // Reset mid-read after "12".
        i_sys = 1'b1;
        i_num = 32'd4;
        @(negedge i_clk);
        i_sys = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data = 8'h31;
        @(negedge i_clk);
        i_rx_data = 8'h32;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst ready", 32'(o_rx_ready), 32'd0);
        chk("mid_rst run", 32'(o_run), 32'd0);
        chk("mid_rst res", o_res, 32'd0);
        @(negedge i_clk);
        chk("mid_rst we", 32'(o_res_we), 32'd0);
        chk("mid_rst ready2", 32'(o_rx_ready), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        set_str("7\n");
        do_read(1'b0, 0, "after_rst");

        // Foreign syscall numbers are ignored.
        i_sys = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data = 8'h35;
        for (int c = 0; c < 6; c++) begin
            logic prev_run;
            num = (c == 0) ? 32'd2 : $urandom;
            if (num == 32'd4 || num == 32'd5) num = 32'd6;
            i_num = num;
            prev_run = 1'(c % 2);
            i_run = prev_run;
            @(negedge i_clk);
            chk("other run", 32'(o_run), 32'(prev_run));
            chk("other ready", 32'(o_rx_ready), 32'd0);
            chk("other we", 32'(o_res_we), 32'd0);
            chk("other res", o_res, last_res);
        end
        i_sys = 1'b0;
        i_rx_valid = 1'b0;
        i_run = 1'b1;
        @(negedge i_clk);

        // Randomized reads.
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(3, 0) == 0) begin
                stim.delete();
                stim.push_back(u8'($urandom));
                do_read(1'b1, 2, "rand_char");
            end else begin
                stim.delete();
                nws = $urandom_range(2, 0);
                for (int i = 0; i < nws; i++) begin
                    case ($urandom_range(3, 0))
                        0: stim.push_back(8'h20);
                        1: stim.push_back(8'h09);
                        2: stim.push_back(8'h0A);
                        default: stim.push_back(8'h0D);
                    endcase
                end
                minus = ($urandom_range(3, 0) == 0);
                if (minus) stim.push_back(8'h2D);
                nd = $urandom_range(11, 0);
                for (int i = 0; i < nd; i++) stim.push_back(u8'(8'h30 + $urandom_range(9, 0)));
                if ((nd > 0 || minus) && $urandom_range(1, 0) == 1)
                    stim.push_back(($urandom_range(1, 0) == 1) ? 8'h0A : 8'h20);
                else
                    stim.push_back(($urandom_range(1, 0) == 1) ? 8'h78 : 8'h2C);
                do_read(1'b0, 2, "rand_int");
            end
            for (int g = 0; g < $urandom_range(2, 0); g++) @(negedge i_clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sysread.md
SYSREAD -- requirements
Module: sysread

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
  i_clk  in  1  sole clock; all state changes on rising edge
  i_rst_n  in  1  reset, asynchronous, active-low
  i_sys  in  1  syscall strobe from decode, sampled each rising edge
  i_num  in  32  syscall number
  i_run  in  1  processor run request
  o_run  out  1  registered run enable back to processor (0 = stall)
  i_rx_data  in  8  console input byte
  i_rx_valid  in  1  i_rx_data valid
  o_rx_ready  out  1  byte accepted on edge where i_rx_valid & o_rx_ready
  o_res  out  32  syscall result for register writeback
  o_res_we  out  1  one-cycle writeback strobe for o_res
REQ-002 The block SHALL use a single clock domain, i_clk; reset SHALL be asynchronous and active-low on i_rst_n.

Function
REQ-003 Syscall numbers: 4 = read int, 5 = read char; all other numbers SHALL be ignored by this block.
REQ-004 The FSM SHALL have states IDLE, RCHAR, RINT_SKIP, RINT_DIG, DONE.
REQ-005 IDLE: each edge o_run <= i_run; on i_sys with i_num=5 -> RCHAR, o_run <= 0; with i_num=4 -> RINT_SKIP, o_run <= 0, acc <= 0, neg <= 0.
REQ-006 o_rx_ready SHALL be 1 exactly in RCHAR, RINT_SKIP, RINT_DIG (decoded from state, no registered delay); 0 otherwise.
REQ-007 RCHAR: on accept, o_res <= {24'b0, byte}, -> DONE.
REQ-008 RINT_SKIP: on accept: 0x20/0x09/0x0A/0x0D discarded, stay; '-' -> neg <= 1, -> RINT_DIG; '0'-'9' -> acc <= digit, -> RINT_DIG; any other byte -> o_res <= 0, -> DONE.
REQ-009 RINT_DIG: on accept: digit -> acc <= acc*10 + digit, modulo 2^32, stay; any non-digit is consumed as terminator -> o_res <= neg ? -acc : acc (32-bit two's complement), -> DONE.
REQ-010 '-' followed directly by a non-digit SHALL produce o_res = 0.
REQ-011 DONE: o_res_we = 1 for exactly this one cycle, o_run still 0; next edge -> IDLE, o_run <= i_run.
REQ-012 o_res SHALL hold its last value until the next completed read.
REQ-013 Minimum stall: o_run low 2 cycles (i_sys edge to DONE exit) when a byte is valid in the first read cycle; with no valid byte, the block SHALL wait indefinitely, o_run = 0.
REQ-014 i_sys while not in IDLE SHALL be ignored; a read in progress SHALL NOT be restarted.
REQ-015 With i_rx_valid = 0, acc, neg and state SHALL hold.

Reset
REQ-016 While i_rst_n = 0: state IDLE, o_run = 0, o_res = 0, o_res_we = 0, acc = 0, neg = 0, o_rx_ready = 0.
REQ-017 Reset mid-read SHALL abandon the read with no o_res_we pulse; after reset, no partial acc or neg SHALL carry into the next read.

Verification
REQ-018 Read char: i_run=1, i_sys, i_num=5, next cycle byte 0x41 valid -> o_res=0x00000041, o_res_we high 1 cycle, o_run low 2 cycles then 1.
REQ-019 Read int "  -123\n": 7 bytes accepted -> o_res=0xFFFFFF85, single o_res_we pulse.
REQ-020 Read int "4294967297 " -> o_res=0x00000001 (wrap); "-2147483648\n" -> 0x80000000.
REQ-021 i_sys, i_num=4, i_rx_valid low 10 cycles -> o_run=0, o_rx_ready=1, no o_res_we throughout; then "9\n" -> o_res=9.
REQ-022 Reset asserted after "12" accepted, then released; i_sys, i_num=4, "7\n" -> o_res=7 (not 127); o_rx_ready=0 during reset.
REQ-023 i_sys, i_num=2 with i_rx_valid=1 -> o_run follows i_run, o_rx_ready stays 0, no o_res_we.
